// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared encodings, field widths and helpers for the clock sequencer
package clock_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_SET_HR  = 3'd1,
      ST_SET_MIN = 3'd2,
      ST_SET_SEC = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int SEC_W = 6;
   localparam int MIN_W = 6;
   localparam int HR_W  = 5;

   // Bits needed to hold 0..value-1; never less than one.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         w++;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler that emits a one-cycle tick every DIV clocks, with synchronous clear
module tick_gen
   import clock_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // Clear holds the count at zero so a resumed second is always a full one.
   assign tick = !clear && (count == LAST);

endmodule

// File: rtl/clock_seq_ctrl.sv
// rtl/clock_seq_ctrl.sv - sequencer for the cascaded sec/min/hr counters of the up/down clock
module clock_seq_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1,
   parameter int SEC_MAX = 59,
   parameter int MIN_MAX = 59,
   parameter int HR_MAX  = 23
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            dir,
   input  logic            btn_mode,
   input  logic            btn_inc,
   input  logic            btn_dec,
   input  logic [SEC_W-1:0] sec,
   input  logic [MIN_W-1:0] min,
   input  logic [HR_W-1:0]  hr,
   output logic            sec_en,
   output logic            min_en,
   output logic            hr_en,
   output logic            up,
   output logic [2:0]      state,
   output logic            done
);

   localparam int               DIV      = CLK_HZ / TICK_HZ;
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
   localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);

   if (DIV < 2 || HR_MAX < 1) begin : g_bad_cfg
      $error("clock_seq_ctrl: CLK_HZ/TICK_HZ must be >= 2 and HR_MAX >= 1");
   end

   state_t st;
   logic   mode_q, inc_q, dec_q;
   logic   mode_e, inc_e, dec_e;
   logic   tick;
   logic   sec_wrap, min_wrap, all_zero;

   assign state = st;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (st != ST_RUN || !run),
      .tick  (tick)
   );

   // Carry conditions depend on the direction the counters are about to step.
   assign sec_wrap = dir ? (sec == SEC_LAST) : (sec == '0);
   assign min_wrap = dir ? (min == MIN_LAST) : (min == '0);
   assign all_zero = (sec == '0) && (min == '0) && (hr == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st     <= ST_RUN;
         sec_en <= 1'b0;
         min_en <= 1'b0;
         hr_en  <= 1'b0;
         up     <= 1'b1;
         done   <= 1'b0;
         mode_q <= 1'b0;
         inc_q  <= 1'b0;
         dec_q  <= 1'b0;
         mode_e <= 1'b0;
         inc_e  <= 1'b0;
         dec_e  <= 1'b0;
      end else begin
         sec_en <= 1'b0;
         min_en <= 1'b0;
         hr_en  <= 1'b0;
         mode_q <= btn_mode;
         inc_q  <= btn_inc;
         dec_q  <= btn_dec;
         mode_e <= btn_mode & ~mode_q;
         inc_e  <= btn_inc & ~inc_q;
         dec_e  <= btn_dec & ~dec_q;

         case (st)
            ST_RUN: begin
               if (tick) begin
                  up <= dir;
                  if (dir || !all_zero) begin
                     sec_en <= 1'b1;
                     min_en <= sec_wrap;
                     hr_en  <= sec_wrap && min_wrap;
                  end else if (!mode_e) begin
                     st   <= ST_DONE;
                     done <= 1'b1;
                  end
               end
               if (mode_e) begin
                  st <= ST_SET_HR;
               end
            end
            ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
               if (mode_e) begin
                  st <= (st == ST_SET_HR)  ? ST_SET_MIN :
                        (st == ST_SET_MIN) ? ST_SET_SEC : ST_RUN;
               end else if (inc_e ^ dec_e) begin
                  up     <= inc_e;
                  hr_en  <= (st == ST_SET_HR);
                  min_en <= (st == ST_SET_MIN);
                  sec_en <= (st == ST_SET_SEC);
               end
            end
            ST_DONE: begin
               if (mode_e) begin
                  st   <= ST_SET_HR;
                  done <= 1'b0;
               end
            end
            default: begin
               st   <= ST_RUN;
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_seq_ctrl.sv
// tb/tb_clock_seq_ctrl.sv - randomized self-checking bench against a time-in-seconds reference model
module tb_clock_seq_ctrl;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       rst, run, dir, btn_mode, btn_inc, btn_dec;
   logic [5:0] sec, min;
   logic [4:0] hr;
   logic       sec_en, min_en, hr_en, up, done;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   int       m_state, m_phase;
   bit [2:0] m_prev, m_edge;
   bit       e_sec, e_min, e_hr, e_up, e_done;

   always #5 clk = ~clk;

   clock_seq_ctrl #(
      .CLK_HZ  (10),
      .TICK_HZ (1),
      .SEC_MAX (59),
      .MIN_MAX (59),
      .HR_MAX  (23)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .dir      (dir),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .btn_dec  (btn_dec),
      .sec      (sec),
      .min      (min),
      .hr       (hr),
      .sec_en   (sec_en),
      .min_en   (min_en),
      .hr_en    (hr_en),
      .up       (up),
      .state    (state),
      .done     (done)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_phase = 0;
      m_prev  = '0;
      m_edge  = '0;
      e_sec   = 0;
      e_min   = 0;
      e_hr    = 0;
      e_up    = 1;
      e_done  = 0;
   endtask

   // Advances the model across one rising edge using the inputs currently driven.
   // Carries come from whole-time arithmetic: a field steps when its quotient changes.
   task automatic model_step();
      int       t;
      bit       tick;
      bit [2:0] btn;
      btn     = {btn_dec, btn_inc, btn_mode};
      tick    = (m_state == 0) && run && (m_phase == DIV - 1);
      m_phase = (m_state == 0 && run) ? (m_phase + 1) % DIV : 0;
      t       = int'(hr) * 3600 + int'(min) * 60 + int'(sec);
      e_sec   = 0;
      e_min   = 0;
      e_hr    = 0;
      if (m_state == 0) begin
         if (tick) begin
            e_up = dir;
            if (dir) begin
               e_sec = 1;
               e_min = ((t + 1) / 60) != (t / 60);
               e_hr  = ((t + 1) / 3600) != (t / 3600);
            end else if (t > 0) begin
               e_sec = 1;
               e_min = ((t - 1) / 60) != (t / 60);
               e_hr  = ((t - 1) / 3600) != (t / 3600);
            end else if (!m_edge[0]) begin
               m_state = 4;
               e_done  = 1;
            end
         end
         if (m_edge[0]) m_state = 1;
      end else if (m_state == 4) begin
         if (m_edge[0]) begin
            m_state = 1;
            e_done  = 0;
         end
      end else if (m_edge[0]) begin
         m_state = (m_state + 1) % 4;
      end else if (m_edge[1] != m_edge[2]) begin
         e_up = m_edge[1];
         case (m_state)
            1:       e_hr  = 1;
            2:       e_min = 1;
            default: e_sec = 1;
         endcase
      end
      m_edge = btn & ~m_prev;
      m_prev = btn;
   endtask

   task automatic check_outputs();
      check_val("sec_en", {31'd0, sec_en}, {31'd0, e_sec});
      check_val("min_en", {31'd0, min_en}, {31'd0, e_min});
      check_val("hr_en",  {31'd0, hr_en},  {31'd0, e_hr});
      check_val("up",     {31'd0, up},     {31'd0, e_up});
      check_val("done",   {31'd0, done},   {31'd0, e_done});
      check_val("state",  {29'd0, state},  32'(m_state));
   endtask

   function automatic int pick(input int max_val);
      case ($urandom_range(0, 2))
         0:       return 0;
         1:       return max_val;
         default: return int'($urandom_range(0, max_val));
      endcase
   endfunction

   task automatic randomize_inputs();
      run = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 30) == 0) dir = ~dir;
      if ($urandom_range(0, 39) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 3) == 0)  btn_inc  = ~btn_inc;
      if ($urandom_range(0, 3) == 0)  btn_dec  = ~btn_dec;
      sec = 6'(pick(59));
      min = 6'(pick(59));
      hr  = 5'(pick(23));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      int first;
      rst      = 1;
      run      = 1;
      dir      = 1;
      btn_mode = 0;
      btn_inc  = 0;
      btn_dec  = 0;
      sec      = 6'd30;
      min      = 6'd30;
      hr       = 5'd12;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      check_outputs();

      rst = 0;
      repeat (4) cycle();
      rst = 1;
      #1;
      model_reset();
      check_outputs();
      #2 rst = 0;

      first = -1;
      for (int i = 0; i < 25; i++) begin
         cycle();
         if (sec_en && first < 0) first = i + 1;
      end
      check_val("first_tick", 32'(first), 32'(DIV));

      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 699) == 0) begin
            rst = 1;
            #1;
            model_reset();
            check_outputs();
            #2 rst = 0;
         end
         randomize_inputs();
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
